sprite_scheduler: RTL and testbench
===================================

SPRITE_SCHEDULER -- requirements
Module: sprite_scheduler

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 4, number of sprite slots (2..8).
REQ-002 SHALL have parameter SPRITE_W, default 5, sprite width in pixels.
REQ-003 SHALL have parameter SPRITE_H, default 5, sprite height in lines.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports h_count and v_count, input, 10 each, current raster pixel.
REQ-007 SHALL have port frame_start, input, 1, one-cycle pulse at the frame boundary.
REQ-008 SHALL have port wr_valid, input, 1, host position-write request.
REQ-009 SHALL have port wr_ready, output, 1, write accepted when wr_valid and wr_ready are both high.
REQ-010 SHALL have port wr_id, input, clog2(NUM_SPRITES), target slot.
REQ-011 SHALL have ports wr_x and wr_y, input, 10 each, new sprite origin.
REQ-012 SHALL have port wr_en, input, 1, new slot enable.
REQ-013 SHALL have port sprite_hit, output, 1, an enabled sprite covers the pixel.
REQ-014 SHALL have port sprite_id, output, clog2(NUM_SPRITES), winning slot.
REQ-015 SHALL have ports i_pos and j_pos, output, 10 each, pixel offset inside the winning sprite.

Function
REQ-016 SHALL hold per-slot shadow registers (x, y, en) and per-slot active registers (x, y, en).
REQ-017 SHALL write an accepted request into the shadow registers of slot wr_id on the next clock edge; a wr_id of NUM_SPRITES or more SHALL be accepted and discarded.
REQ-018 SHALL implement FSM states RUN and COMMIT: RUN goes to COMMIT on frame_start; COMMIT always returns to RUN after one cycle.
REQ-019 SHALL drive wr_ready high in RUN and low in COMMIT.
REQ-020 SHALL copy all shadow registers to the active registers in the COMMIT cycle; a write accepted in the same cycle as frame_start SHALL be included in that commit.
REQ-021 SHALL treat frame_start asserted while in COMMIT as ignored (no second commit).
REQ-022 SHALL flag slot k as hit when en[k]=1, h_count>=x[k], h_count-x[k]<SPRITE_W, v_count>=y[k] and v_count-y[k]<SPRITE_H; subtraction is 10-bit unsigned and SHALL NOT wrap to a hit.
REQ-023 SHALL resolve multiple hits by fixed priority, with the lowest slot index winning.
REQ-024 SHALL register sprite_hit, sprite_id, i_pos=h_count-x[win] and j_pos=v_count-y[win] with one-cycle latency from h_count/v_count.
REQ-025 SHALL drive sprite_id, i_pos and j_pos to 0 when sprite_hit is 0.
REQ-026 SHALL use active registers only for hit detection; shadow contents SHALL never affect outputs before a commit.

Reset
REQ-027 SHALL on rst_n low asynchronously clear all shadow and active registers, set state to RUN, and drive sprite_hit, sprite_id, i_pos, j_pos (and collision) to 0.
REQ-028 SHALL assert wr_ready in the first cycle after rst_n deasserts.
REQ-029 SHALL on reset during COMMIT abort the copy, leaving the active registers cleared.

Configuration
REQ-030 With SPRITE_COLLISION_EN defined, SHALL provide output collision (1 bit), set from a sticky flag that records two or more slots hit on the same pixel during a frame; the value SHALL be transferred to collision and the sticky flag cleared in the COMMIT cycle.
REQ-031 Without SPRITE_COLLISION_EN, the collision port and its logic SHALL be absent.

Structure
REQ-032 SHALL place coord_t (10-bit), the sched_state_t enum (RUN, COMMIT) and the default SPRITE_W and SPRITE_H constants in package sprite_pkg.
REQ-033 SHALL instantiate one sub-module, sprite_hit_unit (per-slot compare and offset subtract), once per slot.

Verification
REQ-034 Reset, then write slot0 x=100 y=50 en=1; before frame_start, raster (102,52) -> sprite_hit=0; after commit, raster (102,52) -> hit=1, id=0, i=2, j=2 one cycle later.
REQ-035 Slots 1 and 2 both cover (200,200) -> id=1; disable slot 1 and commit -> id=2.
REQ-036 Write with wr_valid in the same cycle as frame_start -> value active after COMMIT; wr_ready=0 exactly in the COMMIT cycle.
REQ-037 Slot at x=1020, raster h_count=2 -> no hit (no wrap); raster h_count=1024-1, i.e. offset 3 -> hit with i=3.
REQ-038 With SPRITE_COLLISION_EN, overlap two sprites for a frame -> collision=1 after the next commit, then 0 after the following clean frame.
REQ-039 Assert rst_n mid-frame with sprites active -> all outputs 0 immediately; sprite_hit stays 0 until new writes are committed.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite scheduler: coordinates, scheduler state, slot record.
package sprite_pkg;

    localparam int COORD_W      = 10;
    localparam int SPRITE_W_DEF = 5;
    localparam int SPRITE_H_DEF = 5;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        COMMIT = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic   en;
        coord_t x;
        coord_t y;
    } slot_t;

    // pos lies in [org, org+span) without letting the unsigned difference wrap into a hit
    function automatic logic in_span(coord_t pos, coord_t org, int unsigned span);
        coord_t d;
        d = pos - org;
        return (pos >= org) && (d < coord_t'(span));
    endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// Per-slot coverage test and in-sprite offset for the current raster pixel.
module sprite_hit_unit
    import sprite_pkg::*;
#(
    parameter int SPRITE_W = SPRITE_W_DEF,
    parameter int SPRITE_H = SPRITE_H_DEF
) (
    input  coord_t h_count_i,
    input  coord_t v_count_i,
    input  slot_t  slot_i,
    output logic   hit_o,
    output coord_t i_off_o,
    output coord_t j_off_o
);

    assign i_off_o = h_count_i - slot_i.x;
    assign j_off_o = v_count_i - slot_i.y;
    assign hit_o   = slot_i.en
                   && in_span(h_count_i, slot_i.x, SPRITE_W)
                   && in_span(v_count_i, slot_i.y, SPRITE_H);

endmodule

// File: rtl/sprite_scheduler.sv
// Double-buffered sprite position table with frame-boundary commit and priority hit output.
// Optional feature: define SPRITE_COLLISION_EN to add the per-frame collision output.
module sprite_scheduler
    import sprite_pkg::*;
#(
    parameter int  NUM_SPRITES = 4,
    parameter int  SPRITE_W    = SPRITE_W_DEF,
    parameter int  SPRITE_H    = SPRITE_H_DEF,
    localparam int IDW         = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [9:0]     h_count,
    input  logic [9:0]     v_count,
    input  logic           frame_start,
    input  logic           wr_valid,
    output logic           wr_ready,
    input  logic [IDW-1:0] wr_id,
    input  logic [9:0]     wr_x,
    input  logic [9:0]     wr_y,
    input  logic           wr_en,
`ifdef SPRITE_COLLISION_EN
    output logic           collision,
`endif
    output logic           sprite_hit,
    output logic [IDW-1:0] sprite_id,
    output logic [9:0]     i_pos,
    output logic [9:0]     j_pos
);

    sched_state_t state_q, state_d;
    slot_t [NUM_SPRITES-1:0] shadow_q, shadow_d;
    slot_t [NUM_SPRITES-1:0] active_q, active_d;

    logic   [NUM_SPRITES-1:0] hit_vec;
    coord_t [NUM_SPRITES-1:0] i_off, j_off;

    logic           win_hit;
    logic [IDW-1:0] win_id;
    coord_t         win_i, win_j;

    logic           hit_q;
    logic [IDW-1:0] id_q;
    coord_t         i_q, j_q;

    assign wr_ready = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (frame_start) state_d = COMMIT;
            COMMIT:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Out-of-range ids match no slot, so the write is accepted and dropped
    always_comb begin
        shadow_d = shadow_q;
        if (wr_valid && wr_ready) begin
            for (int k = 0; k < NUM_SPRITES; k++) begin
                if (int'(wr_id) == k) shadow_d[k] = '{en: wr_en, x: wr_x, y: wr_y};
            end
        end
    end

    assign active_d = (state_q == COMMIT) ? shadow_q : active_q;

    for (genvar k = 0; k < NUM_SPRITES; k++) begin : g_slot
        sprite_hit_unit #(
            .SPRITE_W (SPRITE_W),
            .SPRITE_H (SPRITE_H)
        ) u_hit (
            .h_count_i (h_count),
            .v_count_i (v_count),
            .slot_i    (active_q[k]),
            .hit_o     (hit_vec[k]),
            .i_off_o   (i_off[k]),
            .j_off_o   (j_off[k])
        );
    end

    // Scan high to low so the lowest hitting slot is the last assignment
    always_comb begin
        win_hit = 1'b0;
        win_id  = '0;
        win_i   = '0;
        win_j   = '0;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                win_hit = 1'b1;
                win_id  = IDW'(k);
                win_i   = i_off[k];
                win_j   = j_off[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            shadow_q <= '0;
            active_q <= '0;
            hit_q    <= 1'b0;
            id_q     <= '0;
            i_q      <= '0;
            j_q      <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            hit_q    <= win_hit;
            id_q     <= win_id;
            i_q      <= win_i;
            j_q      <= win_j;
        end
    end

    assign sprite_hit = hit_q;
    assign sprite_id  = id_q;
    assign i_pos      = i_q;
    assign j_pos      = j_q;

`ifdef SPRITE_COLLISION_EN
    logic multi_hit;
    logic sticky_q, sticky_d;
    logic coll_q, coll_d;

    assign multi_hit = ($countones(hit_vec) >= 2);

    // The commit-cycle pixel still counts toward the frame being closed
    always_comb begin
        sticky_d = sticky_q | multi_hit;
        coll_d   = coll_q;
        if (state_q == COMMIT) begin
            coll_d   = sticky_q | multi_hit;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
            coll_q   <= coll_d;
        end
    end

    assign collision = coll_q;
`endif

endmodule

// File: tb/tb_sprite_scheduler.sv
// Self-checking bench for sprite_scheduler: directed scenarios plus random traffic against a reference model.
module tb_sprite_scheduler;

    localparam int NS  = 4;
    localparam int SW  = 5;
    localparam int SH  = 5;
    localparam int IDW = $clog2(NS);

    logic           clk = 1'b0;
    logic           rst_n;
    logic [9:0]     h_count, v_count;
    logic           frame_start, wr_valid, wr_en;
    logic           wr_ready;
    logic [IDW-1:0] wr_id;
    logic [9:0]     wr_x, wr_y;
    logic           sprite_hit;
    logic [IDW-1:0] sprite_id;
    logic [9:0]     i_pos, j_pos;
`ifdef SPRITE_COLLISION_EN
    logic           collision;
`endif

    always #5 clk = ~clk;

    sprite_scheduler #(.NUM_SPRITES(NS), .SPRITE_W(SW), .SPRITE_H(SH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .h_count     (h_count),
        .v_count     (v_count),
        .frame_start (frame_start),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_id       (wr_id),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_en       (wr_en),
`ifdef SPRITE_COLLISION_EN
        .collision   (collision),
`endif
        .sprite_hit  (sprite_hit),
        .sprite_id   (sprite_id),
        .i_pos       (i_pos),
        .j_pos       (j_pos)
    );

    int checks = 0;
    int failures = 0;

    // reference model: shadow/active tables, commit phase flag, expected outputs
    int sx[NS], sy[NS], sen[NS];
    int ax[NS], ay[NS], aen[NS];
    bit m_commit;
    bit m_sticky;
    int e_hit, e_id, e_i, e_j, e_coll;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NS; k++) begin
            sx[k] = 0; sy[k] = 0; sen[k] = 0;
            ax[k] = 0; ay[k] = 0; aen[k] = 0;
        end
        m_commit = 0; m_sticky = 0;
        e_hit = 0; e_id = 0; e_i = 0; e_j = 0; e_coll = 0;
    endtask

    // Which active sprites cover (h,v): lowest index wins, count of covering sprites returned
    task automatic eval(input int h, input int v, output int hit, output int id,
                        output int oi, output int oj, output int cnt);
        hit = 0; id = 0; oi = 0; oj = 0; cnt = 0;
        for (int k = 0; k < NS; k++) begin
            if (aen[k] != 0 && h - ax[k] >= 0 && h - ax[k] < SW &&
                v - ay[k] >= 0 && v - ay[k] < SH) begin
                cnt++;
                if (hit == 0) begin
                    hit = 1; id = k; oi = h - ax[k]; oj = v - ay[k];
                end
            end
        end
    endtask

    task automatic check_out(input string tag);
        check({tag, ".hit"}, 32'(sprite_hit), 32'(e_hit));
        check({tag, ".id"},  32'(sprite_id),  32'(e_id));
        check({tag, ".i"},   32'(i_pos),      32'(e_i));
        check({tag, ".j"},   32'(j_pos),      32'(e_j));
        check({tag, ".rdy"}, 32'(wr_ready),   32'(m_commit ? 0 : 1));
`ifdef SPRITE_COLLISION_EN
        check({tag, ".coll"}, 32'(collision), 32'(e_coll));
`endif
    endtask

    // One clock: update the model from the inputs seen at the edge, then check outputs
    task automatic tick(input string tag);
        int hit, id, oi, oj, cnt;
        eval(int'(h_count), int'(v_count), hit, id, oi, oj, cnt);
        if (m_commit) begin
            e_coll   = (m_sticky || cnt >= 2) ? 1 : 0;
            m_sticky = 0;
            for (int k = 0; k < NS; k++) begin
                ax[k] = sx[k]; ay[k] = sy[k]; aen[k] = sen[k];
            end
            m_commit = 0;
        end else begin
            if (cnt >= 2) m_sticky = 1;
            if (wr_valid && int'(wr_id) < NS) begin
                sx[wr_id] = int'(wr_x); sy[wr_id] = int'(wr_y); sen[wr_id] = int'(wr_en);
            end
            if (frame_start) m_commit = 1;
        end
        e_hit = hit; e_id = id; e_i = oi; e_j = oj;
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic write(input int id, input int x, input int y, input bit en);
        wr_valid = 1'b1; wr_id = IDW'(id); wr_x = 10'(x); wr_y = 10'(y); wr_en = en;
        tick("write");
        wr_valid = 1'b0;
    endtask

    task automatic probe(input int h, input int v, input string tag);
        h_count = 10'(h); v_count = 10'(v);
        tick(tag);
    endtask

    // frame_start optionally held into the commit cycle, where it must be ignored
    task automatic commit(input bit hold);
        frame_start = 1'b1;
        tick("fs");
        frame_start = hold;
        tick("commit");
        frame_start = 1'b0;
        tick("post");
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_out(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; h_count = '0; v_count = '0; frame_start = 1'b0;
        wr_valid = 1'b0; wr_id = '0; wr_x = '0; wr_y = '0; wr_en = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check_out("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_out("rdy_after_reset");

        // shadow write invisible until commit
        write(0, 100, 50, 1);
        probe(102, 52, "pre_commit");
        commit(0);
        probe(102, 52, "post_commit");
        check("slot0_hit", 32'(sprite_hit), 32'd1);
        check("slot0_i",   32'(i_pos),      32'd2);

        // priority between overlapping slots
        write(1, 198, 197, 1);
        write(2, 200, 200, 1);
        commit(0);
        probe(200, 200, "prio12");
        check("prio_id1", 32'(sprite_id), 32'd1);
        probe(205, 204, "outside");
        write(1, 198, 197, 0);
        probe(200, 200, "prio_pre");
        commit(1);
        probe(200, 200, "prio2");
        check("prio_id2", 32'(sprite_id), 32'd2);
        probe(0, 0, "clean_px");
        commit(0);

        // write in the frame_start cycle lands in that commit
        wr_valid = 1'b1; wr_id = 2'd3; wr_x = 10'd300; wr_y = 10'd10; wr_en = 1'b1;
        frame_start = 1'b1;
        tick("wr_fs");
        wr_valid = 1'b0; frame_start = 1'b0;
        tick("wr_fs_commit");
        probe(304, 14, "wr_fs_hit");
        check("wr_fs_id", 32'(sprite_id), 32'd3);

        // no wrap of the unsigned offset near the right edge
        write(3, 1020, 0, 1);
        commit(0);
        probe(2, 0, "nowrap");
        probe(1023, 4, "edge");
        check("edge_i", 32'(i_pos), 32'd3);

        // reset mid-frame, then reset while committing
        async_reset("rst_mid");
        probe(1023, 4, "rst_stale");
        probe(200, 200, "rst_stale2");
        write(0, 10, 10, 1);
        frame_start = 1'b1;
        tick("fs_rst");
        frame_start = 1'b0;
        async_reset("rst_commit");
        probe(10, 10, "abort_commit");
        commit(0);
        probe(12, 11, "recommit");

        // random traffic
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 2)
                write(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 40)),
                      int'($urandom_range(0, 40)), bit'($urandom_range(0, 3) != 0));
            else if (r <= 7)
                probe(int'($urandom_range(0, 46)), int'($urandom_range(0, 46)), "rnd");
            else if (r == 8)
                commit(bit'($urandom_range(0, 1)));
            else
                probe(int'($urandom_range(1015, 1023)), int'($urandom_range(0, 8)), "rnd_edge");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
